// File: rtl/sha3_digest_scan_out.sv
// Captures the SHA3 digest on a rising complete edge and unloads it as CHUNK_W chunks, lowest first.
// Optional scan_parity output (XOR of the current chunk) is enabled by defining SCAN_OUT_PARITY_EN.
module sha3_digest_scan_out #(
  parameter int unsigned DIGEST_W = 256,
  parameter int unsigned CHUNK_W  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                complete,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                scan_ready,
  output logic                scan_valid,
  output logic [CHUNK_W-1:0]  scan_out,
  output logic                scan_last,
  output logic                busy,
  output logic                overrun
`ifdef SCAN_OUT_PARITY_EN
  ,
  output logic                scan_parity
`endif
);

  localparam int unsigned NUM_CHUNK = DIGEST_W / CHUNK_W;
  localparam int unsigned IDX_W     = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNK - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGEST_W-1:0] shadow_q, shadow_d;
  logic                complete_q;
  logic                overrun_d;
  logic                cap;
  logic                xfer;
  logic [CHUNK_W-1:0]  chunk_d;

  // Next-state, capture and overrun decisions; outputs are precomputed here and registered below.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    overrun_d = overrun;
    cap       = enable & complete & ~complete_q;
    xfer      = scan_valid & scan_ready;
    chunk_d   = '0;

    case (state_q)
      IDLE: begin
        if (cap) begin
          shadow_d = digest;
          idx_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            // A capture landing on the final transfer chains straight into the next unload.
            if (cap) shadow_d = digest;
            else     state_d  = IDLE;
          end else begin
            idx_d = IDX_W'(idx_q + 1'b1);
            if (cap) overrun_d = 1'b1;
          end
        end else if (cap) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < int'(NUM_CHUNK); i++) begin
      if (idx_d == IDX_W'(i)) chunk_d = shadow_d[i*CHUNK_W +: CHUNK_W];
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      complete_q  <= 1'b0;
      overrun     <= 1'b0;
      scan_valid  <= 1'b0;
      scan_last   <= 1'b0;
      busy        <= 1'b0;
      scan_out    <= '0;
`ifdef SCAN_OUT_PARITY_EN
      scan_parity <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      complete_q  <= complete;
      overrun     <= overrun_d;
      scan_valid  <= (state_d == SHIFT);
      scan_last   <= (state_d == SHIFT) && (idx_d == LAST_IDX);
      busy        <= (state_d == SHIFT);
      scan_out    <= chunk_d;
`ifdef SCAN_OUT_PARITY_EN
      scan_parity <= ^chunk_d;
`endif
    end
  end

endmodule
